// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller.
// Owns the tag/valid/dirty/data arrays. It resolves CPU hits combinationally.
// On a miss it writes back a dirty victim, fetches the new block and installs it.
module dcache_controller #(
    parameter int TAG_W    = 3,
    parameter int INDEX_W  = 3,
    parameter int OFFSET_W = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              read,
    input  logic                              write,
    input  logic [TAG_W+INDEX_W+OFFSET_W-1:0] address,
    input  logic [7:0]                        writedata,
    output logic [7:0]                        readdata,
    output logic                              busywait,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic [TAG_W+INDEX_W-1:0]          mem_address,
    output logic [(8<<OFFSET_W)-1:0]          mem_writedata,
    input  logic [(8<<OFFSET_W)-1:0]          mem_readdata,
    input  logic                              mem_busywait
);

    localparam int LINES   = 1 << INDEX_W;
    localparam int BLOCK_W = 8 << OFFSET_W;
    localparam int ADDR_W  = TAG_W + INDEX_W + OFFSET_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } state_t;

    state_t state, state_next;

    // Per-line storage; valid/dirty are flat vectors so reset can clear them in one step.
    logic [TAG_W-1:0]   tag_arr  [LINES];
    logic [BLOCK_W-1:0] data_arr [LINES];
    logic [LINES-1:0]   valid_arr;
    logic [LINES-1:0]   dirty_arr;

    logic [BLOCK_W-1:0] fill_q;       // block captured when the fetch completes
    logic [7:0]         readdata_q;   // last byte returned on a read hit

    logic [TAG_W-1:0]    addr_tag;
    logic [INDEX_W-1:0]  idx;
    logic [OFFSET_W-1:0] off;
    logic                hit;
    logic                write_hit;
    logic [7:0]          sel_byte;

    assign addr_tag  = address[ADDR_W-1 -: TAG_W];
    assign idx       = address[OFFSET_W +: INDEX_W];
    assign off       = address[OFFSET_W-1:0];
    assign hit       = valid_arr[idx] && (tag_arr[idx] == addr_tag);
    assign sel_byte  = data_arr[idx][{off, 3'b000} +: 8];
    // A store only lands while the FSM is idle; a miss first refills, then retries as a hit.
    assign write_hit = (state == IDLE) && write && hit;

    // CPU-side outputs: stall until the access hits in IDLE; the read byte holds between hits.
    always_comb begin
        busywait = (read || write) && ((state != IDLE) || !hit);
        readdata = (read && hit) ? sel_byte : readdata_q;
    end

    // The victim address comes from the stored tag; the fetch address comes from the CPU tag.
    always_comb begin
        mem_address   = (state == WRITEBACK) ? {tag_arr[idx], idx} : {addr_tag, idx};
        mem_writedata = data_arr[idx];
    end

    // Next-state logic for the miss-handling sequence.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path covered, so no latch is inferred.
        state_next = state;
        case (state)
            IDLE: begin
                if ((read || write) && !hit)
                    state_next = (valid_arr[idx] && dirty_arr[idx]) ? WRITEBACK : FETCH;
            end
            WRITEBACK: if (!mem_busywait) state_next = FETCH;
            FETCH:     if (!mem_busywait) state_next = UPDATE;
            UPDATE:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // State register and registered memory request strobes, derived from the upcoming state.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments let every flop sample pre-edge values, which mirrors the hardware.
        if (reset) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            state     <= state_next;
            mem_read  <= (state_next == FETCH);
            mem_write <= (state_next == WRITEBACK);
        end
    end

    // Valid/dirty flags: cleared by reset, set on install, and the dirty flag is set by a store hit.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_arr <= '0;
            dirty_arr <= '0;
        end else if (state == UPDATE) begin
            valid_arr[idx] <= 1'b1;
            dirty_arr[idx] <= 1'b0;
        end else if (write_hit) begin
            dirty_arr[idx] <= 1'b1;
        end
    end

    // Tag/data storage and the fill buffer; the line install and the byte store never coincide.
    always_ff @(posedge clock) begin
        // NOTE: tag/data/fill are not reset; a cleared valid bit makes their contents irrelevant.
        if (state == FETCH && !mem_busywait)
            fill_q <= mem_readdata;
        if (state == UPDATE) begin
            data_arr[idx] <= fill_q;
            tag_arr[idx]  <= addr_tag;
        end else if (write_hit) begin
            data_arr[idx][{off, 3'b000} +: 8] <= writedata;
        end
    end

    // Hold the most recent read-hit byte so that readdata stays stable between accesses.
    always_ff @(posedge clock) begin
        if (reset)
            readdata_q <= '0;
        else if (read && hit)
            readdata_q <= sel_byte;
    end

endmodule
